hazard_ctrl: RTL and testbench

Pipeline hazard and segment controller for the five-stage CPU. Sits beside the operand-forwarding logic in ID/EX and drives the stall/flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB segment registers. Resolves three hazard classes:
- load-use hazards, which forwarding cannot cover;
- taken branches/jumps resolved in EX;
- multi-cycle data-memory accesses.

Also keeps a wait watchdog and saturating performance counters.

---
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the five-stage pipeline.
// Resolves load-use hazards, taken branches resolved in EX and multi-cycle
// data-memory accesses (with a wait watchdog), and keeps saturating counters.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   rf_ra0_id/rf_ra1_id       source register addresses of the ID instruction
//   rf_re0_id/rf_re1_id       source actually read by the ID instruction
//   rf_wa_ex/rf_we_ex         destination and write enable of the EX instruction
//   rf_wd_sel_ex              EX write-back source (2'b10 = memory load)
//   npc_sel_ex                branch/jump taken in EX
//   dmem_req_mem/dmem_ack     data-memory request in MEM / completion
//   stall_*                   hold PC and segment registers (combinational)
//   flush_if_id/flush_id_ex   load a bubble into IF/ID, ID/EX (combinational)
//   mem_err                   sticky timeout flag; rises in the release cycle
//   stall_cycles              saturating count of cycles with stall_pc=1
//   flush_events              saturating count of cycles with flush_if_id=1
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rf_ra0_id,
  input  logic [4:0]  rf_ra1_id,
  input  logic        rf_re0_id,
  input  logic        rf_re1_id,
  input  logic [4:0]  rf_wa_ex,
  input  logic        rf_we_ex,
  input  logic [1:0]  rf_wd_sel_ex,
  input  logic        npc_sel_ex,
  input  logic        dmem_req_mem,
  input  logic        dmem_ack,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_mem,
  output logic        stall_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        mem_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  localparam int unsigned WAIT_W = 16;
  localparam int unsigned CTR_W  = 32;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CTR_W-1:0]  CTR_MAX   = {CTR_W{1'b1}};
  localparam logic [1:0]        WD_MEM    = 2'b10;

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;
  logic              load_use;
  logic              timeout_now;
  logic              mem_hold;

  // Hazard detection and next-state logic
  always_comb begin
    state_nxt   = state;
    load_use    = rf_we_ex && (rf_wd_sel_ex == WD_MEM) && (rf_wa_ex != 5'd0) &&
                  ((rf_re0_id && (rf_ra0_id == rf_wa_ex)) ||
                   (rf_re1_id && (rf_ra1_id == rf_wa_ex)));
    timeout_now = (state == MEM_WAIT) && !dmem_ack && (wait_cnt == WAIT_LAST);
    mem_hold    = ((state == RUN) && dmem_req_mem && !dmem_ack) ||
                  ((state == MEM_WAIT) && !dmem_ack && !timeout_now);
    case (state)
      RUN:      if (dmem_req_mem && !dmem_ack) state_nxt = MEM_WAIT;
      MEM_WAIT: if (dmem_ack || timeout_now)   state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // Stall/flush outputs by priority: memory hold, taken branch, load-use
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    if (!rst) begin
      if (mem_hold) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        stall_mem_wb = 1'b1;
      end else if (npc_sel_ex) begin
        // wrong-path ID instruction is discarded, so load_use is moot
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (load_use) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
    end
  end

  // The release cycle of a timed-out access already reports the error
  assign mem_err = err_q | (timeout_now & ~rst);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Wait watchdog: held at zero in RUN, so it starts from zero on entry
  always_ff @(posedge clk) begin
    if (rst)                   wait_cnt <= '0;
    else if (state == RUN)     wait_cnt <= '0;
    else if (!dmem_ack)        wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst)              err_q <= 1'b0;
    else if (timeout_now) err_q <= 1'b1;
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_pc && (stall_cycles != CTR_MAX))
        stall_cycles <= stall_cycles + CTR_W'(1);
      if (flush_if_id && (flush_events != CTR_MAX))
        flush_events <= flush_events + CTR_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized stimulus for hazard_ctrl, checked
// cycle by cycle against a reference model through a scoreboard queue.
module tb_hazard_ctrl;

  localparam int unsigned TO = 4;
  localparam longint unsigned SAT = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rf_ra0_id, rf_ra1_id, rf_wa_ex;
  logic        rf_re0_id, rf_re1_id, rf_we_ex;
  logic [1:0]  rf_wd_sel_ex;
  logic        npc_sel_ex, dmem_req_mem, dmem_ack;
  logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic        flush_if_id, flush_id_ex, mem_err;
  logic [31:0] stall_cycles, flush_events;

  hazard_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .rf_ra0_id(rf_ra0_id), .rf_ra1_id(rf_ra1_id),
    .rf_re0_id(rf_re0_id), .rf_re1_id(rf_re1_id),
    .rf_wa_ex(rf_wa_ex), .rf_we_ex(rf_we_ex), .rf_wd_sel_ex(rf_wd_sel_ex),
    .npc_sel_ex(npc_sel_ex), .dmem_req_mem(dmem_req_mem), .dmem_ack(dmem_ack),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [4:0]  st;
    logic [1:0]  fl;
    logic        err;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model: an access is "outstanding" while the pipeline is held;
  // m_held counts hold cycles spent on it so far (limit TO).
  bit              m_waiting = 1'b0;
  int unsigned     m_held    = 0;
  bit              m_err     = 1'b0;
  longint unsigned m_stalls  = 0;
  longint unsigned m_flushes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp,
                     input logic [31:0] c);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] a0, input logic e0,
                      input logic [4:0] a1, input logic e1, input logic [4:0] wa,
                      input logic we, input logic [1:0] sel, input logic npc,
                      input logic req, input logic ack);
    exp_t e;
    bit   lu, hold, tmo;
    rst = r; rf_ra0_id = a0; rf_re0_id = e0; rf_ra1_id = a1; rf_re1_id = e1;
    rf_wa_ex = wa; rf_we_ex = we; rf_wd_sel_ex = sel;
    npc_sel_ex = npc; dmem_req_mem = req; dmem_ack = ack;

    lu = we && sel == 2'b10 && wa != 5'd0 && ((e0 && a0 == wa) || (e1 && a1 == wa));
    if (m_waiting) begin
      hold = !ack && (m_held < TO);
      tmo  = !ack && (m_held >= TO);
    end else begin
      hold = req && !ack;
      tmo  = 1'b0;
    end
    e.cyc = 32'(cyc);
    e.st  = 5'b0;
    e.fl  = 2'b0;
    if (!r) begin
      if (hold)     e.st = 5'b11111;
      else if (npc) e.fl = 2'b11;
      else if (lu) begin e.st = 5'b11000; e.fl = 2'b01; end
    end
    e.err = m_err || (tmo && !r);
    e.sc  = 32'(m_stalls);
    e.fe  = 32'(m_flushes);
    sb.push_back(e);

    if (r) begin
      m_waiting = 1'b0; m_held = 0; m_err = 1'b0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (hold) begin
        m_held    = m_waiting ? m_held + 1 : 1;
        m_waiting = 1'b1;
      end else begin
        m_waiting = 1'b0;
        m_held    = 0;
      end
      if (tmo) m_err = 1'b1;
      if (e.st[4] && m_stalls < SAT) m_stalls++;
      if (e.fl[1] && m_flushes < SAT) m_flushes++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic req, input logic ack);
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, req, ack);
  endtask

  // Preload counters near saturation instead of running 2^32 cycles
  task automatic preload(input logic [31:0] sc, input logic [31:0] fe);
    force dut.stall_cycles = sc;
    force dut.flush_events = fe;
    #1;
    release dut.stall_cycles;
    release dut.flush_events;
    m_stalls  = longint'(sc);
    m_flushes = longint'(fe);
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(4))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      3: return 5'd9;
      default: return 5'($urandom_range(31));
    endcase
  endfunction

  // Monitor: every cycle presents a full set of outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stalls", 32'({stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb}),
            32'(e.st), e.cyc);
        chk("flushes", 32'({flush_if_id, flush_id_ex}), 32'(e.fl), e.cyc);
        chk("mem_err", 32'(mem_err), 32'(e.err), e.cyc);
        chk("stall_cycles", stall_cycles, e.sc, e.cyc);
        chk("flush_events", flush_events, e.fe, e.cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rf_ra0_id = '0; rf_ra1_id = '0; rf_wa_ex = '0;
    rf_re0_id = 1'b0; rf_re1_id = 1'b0; rf_we_ex = 1'b0; rf_wd_sel_ex = 2'b00;
    npc_sel_ex = 1'b0; dmem_req_mem = 1'b0; dmem_ack = 1'b0;
    @(posedge clk);
    #1;

    // reset state
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    // load x5 then add x6,x5,x1
    step(1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    // x0 destination, unread source, ALU producer
    step(1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd5, 1'b0, 5'd1, 1'b1, 5'd5, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    // taken branch together with load-use
    step(1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    // memory access acked after 3 hold cycles
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    // access never acked: timeout
    idle(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b0, 1'b0);
    // reset in the 2nd MEM_WAIT cycle
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(99) == 0), pick_reg(), 1'($urandom_range(1)),
           pick_reg(), 1'($urandom_range(1)), pick_reg(), 1'($urandom_range(3) != 0),
           2'($urandom_range(3)), 1'($urandom_range(4) == 0),
           1'($urandom_range(4) == 0), 1'($urandom_range(2) == 0));
    end

    // saturation of both counters
    idle(1'b0, 1'b1);
    preload(32'hFFFF_FFFD, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++)
      step(1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1);
    idle(1'b0, 1'b0);

    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0, 32'(cyc));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
